// File: rtl/uart_header_assembler.sv
// Packs single-byte UART strobes into an 80-byte block header for the miner.
// A partial frame that stalls past the idle timeout is discarded.
module uart_header_assembler #(
  parameter int unsigned HEADER_BYTES   = 80,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [7:0]                rx_byte_i,
  input  logic                      rx_valid_i,
  output logic [HEADER_BYTES*8-1:0] header_data_o,
  output logic                      header_valid_o,
  output logic [31:0]               byte_count_o,
  output logic [6:0]                frame_pos_o,
  output logic                      timeout_err_o,
  output logic                      busy_o
);

  localparam int unsigned HDR_W = HEADER_BYTES * 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]       POS_LAST = 7'(HEADER_BYTES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  state_e             state_q,        state_d;
  logic [HDR_W-1:0]   work_q,         work_d;
  logic [HDR_W-1:0]   header_data_q,  header_data_d;
  logic               header_valid_q, header_valid_d;
  logic [31:0]        byte_count_q,   byte_count_d;
  logic [6:0]         frame_pos_q,    frame_pos_d;
  logic               timeout_err_q,  timeout_err_d;
  logic               busy_q,         busy_d;
  logic [CNT_W-1:0]   idle_cnt_q,     idle_cnt_d;
  logic [HDR_W-1:0]   work_shift_s;

  assign work_shift_s = {work_q[HDR_W-9:0], rx_byte_i};

  always_comb begin
    state_d        = state_q;
    work_d         = work_q;
    header_data_d  = header_data_q;
    header_valid_d = 1'b0;
    frame_pos_d    = frame_pos_q;
    timeout_err_d  = 1'b0;
    idle_cnt_d     = idle_cnt_q;

    if (rx_valid_i) begin
      byte_count_d = byte_count_q + 32'd1;
    end else begin
      byte_count_d = byte_count_q;
    end

    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (rx_valid_i) begin
          work_d      = work_shift_s;
          frame_pos_d = 7'd1;
          state_d     = ST_RECV;
        end else begin
          frame_pos_d = 7'd0;
        end
      end
      ST_RECV: begin
        if (rx_valid_i) begin
          idle_cnt_d = '0;
          if (frame_pos_q == POS_LAST) begin
            // Publish the full header and start the next frame from a clean register.
            header_data_d  = work_shift_s;
            header_valid_d = 1'b1;
            work_d         = '0;
            frame_pos_d    = 7'd0;
            state_d        = ST_IDLE;
          end else begin
            work_d      = work_shift_s;
            frame_pos_d = frame_pos_q + 7'd1;
          end
        end else if (idle_cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          work_d        = '0;
          frame_pos_d   = 7'd0;
          idle_cnt_d    = '0;
          state_d       = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d     = ST_IDLE;
        work_d      = '0;
        frame_pos_d = 7'd0;
        idle_cnt_d  = '0;
      end
    endcase

    busy_d = (frame_pos_d != 7'd0);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      work_q         <= '0;
      header_data_q  <= '0;
      header_valid_q <= 1'b0;
      byte_count_q   <= 32'd0;
      frame_pos_q    <= 7'd0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
      idle_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      work_q         <= work_d;
      header_data_q  <= header_data_d;
      header_valid_q <= header_valid_d;
      byte_count_q   <= byte_count_d;
      frame_pos_q    <= frame_pos_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
      idle_cnt_q     <= idle_cnt_d;
    end
  end

  assign header_data_o  = header_data_q;
  assign header_valid_o = header_valid_q;
  assign byte_count_o   = byte_count_q;
  assign frame_pos_o    = frame_pos_q;
  assign timeout_err_o  = timeout_err_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_header_assembler.sv
// Randomized directed bench for uart_header_assembler against a queue-based
// reference model of the frame assembly rules.
module tb_uart_header_assembler;

  localparam int unsigned NB = 80;
  localparam int unsigned TO = 100;

  logic           clock;
  logic           reset;
  logic [7:0]     rx_byte;
  logic           rx_valid;
  logic [NB*8-1:0] header_data;
  logic           header_valid;
  logic [31:0]    byte_count;
  logic [6:0]     frame_pos;
  logic           timeout_err;
  logic           busy;

  uart_header_assembler #(.HEADER_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .rx_byte_i      (rx_byte),
    .rx_valid_i     (rx_valid),
    .header_data_o  (header_data),
    .header_valid_o (header_valid),
    .byte_count_o   (byte_count),
    .frame_pos_o    (frame_pos),
    .timeout_err_o  (timeout_err),
    .busy_o         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model: bytes of the current partial frame in arrival order.
  logic [7:0]      m_bytes[$];
  logic [NB*8-1:0] m_hdr = '0;
  logic            m_hv  = 1'b0;
  logic            m_to  = 1'b0;
  logic [31:0]     m_cnt = 32'd0;
  int unsigned     m_idle = 0;

  function automatic void model_step(input logic r, input logic v, input logic [7:0] b);
    m_hv = 1'b0;
    m_to = 1'b0;
    if (r) begin
      m_bytes.delete();
      m_hdr  = '0;
      m_cnt  = 32'd0;
      m_idle = 0;
    end else if (v) begin
      m_bytes.push_back(b);
      m_cnt  = m_cnt + 32'd1;
      m_idle = 0;
      if (m_bytes.size() == NB) begin
        for (int i = 0; i < NB; i++) m_hdr[(NB*8-1)-8*i -: 8] = m_bytes[i];
        m_hv = 1'b1;
        m_bytes.delete();
      end
    end else if (m_bytes.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_to = 1'b1;
        m_bytes.delete();
        m_idle = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [NB*8-1:0] obs, input logic [NB*8-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("header_data", header_data, m_hdr);
    chk("header_valid", {{(NB*8-1){1'b0}}, header_valid}, {{(NB*8-1){1'b0}}, m_hv});
    chk("byte_count", {{(NB*8-32){1'b0}}, byte_count}, {{(NB*8-32){1'b0}}, m_cnt});
    chk("frame_pos", {{(NB*8-7){1'b0}}, frame_pos}, (NB*8)'(m_bytes.size()));
    chk("timeout_err", {{(NB*8-1){1'b0}}, timeout_err}, {{(NB*8-1){1'b0}}, m_to});
    chk("busy", {{(NB*8-1){1'b0}}, busy}, (NB*8)'(m_bytes.size() != 0));
  endtask

  task automatic tick(input logic v, input logic [7:0] b, input logic r);
    @(negedge clock);
    reset    = r;
    rx_valid = v;
    rx_byte  = b;
    @(posedge clock);
    model_step(r, v, b);
    #1;
    check_all();
  endtask

  task automatic send_frame_gaps(input int unsigned nbytes, input int unsigned max_gap);
    for (int i = 0; i < nbytes; i++) begin
      tick(1'b1, 8'($urandom), 1'b0);
      for (int g = 0; g < $urandom_range(max_gap, 0); g++) tick(1'b0, 8'h00, 1'b0);
    end
  endtask

  int unsigned pulses;
  int unsigned first_hv;
  int unsigned second_hv;
  logic [NB*8-1:0] all_a5;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;

    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    chk("reset_header", header_data, '0);
    tick(1'b0, 8'h00, 1'b0);

    // Counting frame, bytes three cycles apart.
    for (int i = 0; i < NB; i++) begin
      tick(1'b1, 8'(i), 1'b0);
      if (i != NB - 1) begin
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
      end
    end
    chk("count_first_byte", {{(NB*8-8){1'b0}}, header_data[NB*8-1 -: 8]}, (NB*8)'(8'h00));
    chk("count_last_byte", {{(NB*8-8){1'b0}}, header_data[7:0]}, (NB*8)'(8'h4F));
    chk("count_total", {{(NB*8-32){1'b0}}, byte_count}, (NB*8)'(80));
    chk("count_hv", {{(NB*8-1){1'b0}}, header_valid}, (NB*8)'(1));
    tick(1'b0, 8'h00, 1'b0);

    // Partial frame then timeout.
    for (int i = 0; i < 40; i++) tick(1'b1, 8'($urandom), 1'b0);
    pulses = 0;
    for (int i = 0; i < TO; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (timeout_err === 1'b1) pulses++;
    end
    chk("timeout_pulses", (NB*8)'(pulses), (NB*8)'(1));
    tick(1'b0, 8'h00, 1'b0);
    chk("timeout_single", {{(NB*8-1){1'b0}}, timeout_err}, '0);

    for (int i = 0; i < NB; i++) tick(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < NB; i++) all_a5[8*i +: 8] = 8'hA5;
    chk("all_a5", header_data, all_a5);

    // Back-to-back frames, rx_valid every cycle.
    pulses = 0; first_hv = 0; second_hv = 0;
    for (int i = 0; i < 2 * NB; i++) begin
      tick(1'b1, 8'($urandom), 1'b0);
      if (header_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) first_hv = i;
        else second_hv = i;
      end
    end
    chk("b2b_pulses", (NB*8)'(pulses), (NB*8)'(2));
    chk("b2b_spacing", (NB*8)'(second_hv - first_hv), (NB*8)'(NB));
    tick(1'b0, 8'h00, 1'b0);

    // Byte lands exactly on the cycle the timeout would expire.
    for (int i = 0; i < 20; i++) tick(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < TO - 1; i++) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'($urandom), 1'b0);
    chk("edge_no_timeout", {{(NB*8-1){1'b0}}, timeout_err}, '0);
    chk("edge_frame_pos", {{(NB*8-7){1'b0}}, frame_pos}, (NB*8)'(21));
    send_frame_gaps(NB - 21, 3);

    // Reset mid-frame.
    send_frame_gaps(30, 2);
    tick(1'b0, 8'h00, 1'b1);
    chk("rst_header", header_data, '0);
    chk("rst_count", {{(NB*8-32){1'b0}}, byte_count}, '0);
    chk("rst_pos", {{(NB*8-7){1'b0}}, frame_pos}, '0);
    chk("rst_timeout", {{(NB*8-1){1'b0}}, timeout_err}, '0);
    tick(1'b0, 8'h00, 1'b0);
    send_frame_gaps(NB, 3);
    tick(1'b0, 8'h00, 1'b0);

    // byte_count wrap.
    @(negedge clock);
    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_byte  = 8'h3C;
    force dut.byte_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.byte_count_q;
    m_cnt = 32'hFFFF_FFFF;
    @(posedge clock);
    model_step(1'b0, 1'b1, 8'h3C);
    #1;
    check_all();
    chk("wrap_count", {{(NB*8-32){1'b0}}, byte_count}, '0);
    chk("wrap_pos", {{(NB*8-7){1'b0}}, frame_pos}, (NB*8)'(1));
    tick(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
